// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants for the time-of-day path. The timekeeper core and the
// display stage both import this package.
//   - Packed two-digit BCD layout: [7:4] tens digit, [3:0] units digit.
//   - Roll-over limits for seconds, minutes and hours (24-hour format).
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_W       = 2 * BCD_DIGIT_W;

  typedef logic [BCD_W-1:0] bcd2_t;

  localparam bcd2_t SEC_MAX  = 8'h59;
  localparam bcd2_t MIN_MAX  = 8'h59;
  localparam bcd2_t HOUR_MAX = 8'h23;

  // Digit limits split out so counters can be parameterised per digit.
  localparam int SEC_MAX_TENS   = int'(SEC_MAX[7:4]);
  localparam int SEC_MAX_UNITS  = int'(SEC_MAX[3:0]);
  localparam int MIN_MAX_TENS   = int'(MIN_MAX[7:4]);
  localparam int MIN_MAX_UNITS  = int'(MIN_MAX[3:0]);
  localparam int HOUR_MAX_TENS  = int'(HOUR_MAX[7:4]);
  localparam int HOUR_MAX_UNITS = int'(HOUR_MAX[3:0]);

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit packed BCD counter that rolls from {MAX_TENS,MAX_UNITS} to 00.
// Units wrap 9->0 and bump the tens digit, so digits never exceed 9.
//
// Ports
//   clk_16mhz  in   clock, rising edge
//   rst        in   synchronous active-high reset, value <- 00
//   inc        in   advance by one this cycle
//   clr        in   value <- 00, takes priority over inc
//   value      out  [7:4] tens, [3:0] units (registered)
//   carry      out  combinational, high when inc rolls the value over to 00
// ---------------------------------------------------------------------------
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX_TENS  = 5,
  parameter int MAX_UNITS = 9
) (
  input  logic             clk_16mhz,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] value,
  output logic             carry
);

  localparam logic [BCD_DIGIT_W-1:0] TENS_LIM  = BCD_DIGIT_W'(MAX_TENS);
  localparam logic [BCD_DIGIT_W-1:0] UNITS_LIM = BCD_DIGIT_W'(MAX_UNITS);
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
  logic [BCD_DIGIT_W-1:0] units_q, units_d;
  logic                   at_max;

  assign at_max = (tens_q == TENS_LIM) && (units_q == UNITS_LIM);
  assign carry  = inc && !clr && at_max;
  assign value  = {tens_q, units_q};

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_max) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units_q == DIGIT_MAX) begin
        units_d = '0;
        tens_d  = tens_q + 1'b1;
      end else begin
        units_d = units_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// ---------------------------------------------------------------------------
// bcd_timekeeper
// Time-of-day core: divides clk_16mhz down to TICK_HZ and keeps hh:mm:ss
// as packed BCD in 24-hour format, plus a half-period blink phase and a
// midnight pulse.
//
// Ports
//   clk_16mhz    in   system clock, rising edge
//   rst          in   synchronous active-high reset, overrides all inputs
//   en           in   1 = prescaler runs; 0 = prescaler and time frozen
//   inc_min      in   minutes +1 per high cycle, 59->00, no carry to hours
//   inc_hour     in   hours +1 per high cycle, 23->00, no midnight pulse
//   clr_sec      in   seconds <- 00, prescaler <- 0, suppresses the tick
//   hours_bcd    out  [7:4] tens 0-2, [3:0] units
//   minutes_bcd  out  [7:4] tens 0-5, [3:0] units
//   seconds_bcd  out  [7:4] tens 0-5, [3:0] units
//   tick         out  one-cycle pulse in the cycle the advanced time shows
//   half_sec     out  1 while prescaler < DIV/2
//   midnight     out  one-cycle pulse with tick on 23:59:59 -> 00:00:00
// ---------------------------------------------------------------------------
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 16000000,
  parameter int TICK_HZ     = 1
) (
  input  logic             clk_16mhz,
  input  logic             rst,
  input  logic             en,
  input  logic             inc_min,
  input  logic             inc_hour,
  input  logic             clr_sec,
  output logic [BCD_W-1:0] hours_bcd,
  output logic [BCD_W-1:0] minutes_bcd,
  output logic [BCD_W-1:0] seconds_bcd,
  output logic             tick,
  output logic             half_sec,
  output logic             midnight
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("bcd_timekeeper: prescaler modulus %0d must be even and >= 2", DIV);
  end

  localparam logic [PW-1:0] TERM = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  // The prescaler is kept as a down-counter of cycles remaining until the
  // advance strobe: remain = DIV-1 - prescaler. "prescaler < DIV/2" is
  // therefore "remain >= DIV/2".
  logic [PW-1:0] remain_q, remain_d;
  logic          tick_q, midnight_q, half_sec_q;

  logic strobe;
  logic sec_carry, min_carry, hour_carry;
  logic min_inc, hour_inc;
  logic at_last_second;

  // clr_sec on the terminal cycle kills the advance entirely.
  assign strobe = en && (remain_q == '0) && !clr_sec;

  always_comb begin
    remain_d = remain_q;
    if (clr_sec) begin
      remain_d = TERM;
    end else if (en) begin
      remain_d = (remain_q == '0) ? TERM : remain_q - 1'b1;
    end
  end

  // A set pulse coinciding with a ripple carry is OR-ed in, so the field
  // moves by exactly one. The hour carry is only taken from minutes when
  // the roll-over came from seconds; inc_min at 59 leaves hours alone.
  assign min_inc  = inc_min || sec_carry;
  assign hour_inc = inc_hour || (min_carry && sec_carry);

  bcd_mod_counter #(
    .MAX_TENS  (SEC_MAX_TENS),
    .MAX_UNITS (SEC_MAX_UNITS)
  ) u_sec (
    .clk_16mhz (clk_16mhz),
    .rst       (rst),
    .inc       (strobe),
    .clr       (clr_sec),
    .value     (seconds_bcd),
    .carry     (sec_carry)
  );

  bcd_mod_counter #(
    .MAX_TENS  (MIN_MAX_TENS),
    .MAX_UNITS (MIN_MAX_UNITS)
  ) u_min (
    .clk_16mhz (clk_16mhz),
    .rst       (rst),
    .inc       (min_inc),
    .clr       (1'b0),
    .value     (minutes_bcd),
    .carry     (min_carry)
  );

  bcd_mod_counter #(
    .MAX_TENS  (HOUR_MAX_TENS),
    .MAX_UNITS (HOUR_MAX_UNITS)
  ) u_hour (
    .clk_16mhz (clk_16mhz),
    .rst       (rst),
    .inc       (hour_inc),
    .clr       (1'b0),
    .value     (hours_bcd),
    .carry     (hour_carry)
  );

  // Midnight is defined by the time-driven wrap only; hour_carry alone would
  // also fire on inc_hour at 23.
  assign at_last_second = (hours_bcd == HOUR_MAX) && (minutes_bcd == MIN_MAX) &&
                          (seconds_bcd == SEC_MAX);

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      remain_q   <= TERM;
      tick_q     <= 1'b0;
      midnight_q <= 1'b0;
      half_sec_q <= 1'b1;
    end else begin
      remain_q   <= remain_d;
      tick_q     <= strobe;
      midnight_q <= strobe && at_last_second;
      half_sec_q <= (remain_d >= HALF);
    end
  end

  assign tick     = tick_q;
  assign midnight = midnight_q;
  assign half_sec = half_sec_q;

  logic unused_hour_carry;
  assign unused_hour_carry = hour_carry;

endmodule
